// File: rtl/apb_slave_regfile_pkg.sv
// ---------------------------------------------------------------------------
// specConst: constants and types shared by the APB register-file slice.
//   PROT_LEN / STROBE_LEN / RESP_LEN : APB sideband widths
//   state_t                          : transfer FSM state encoding
//   resp_t                           : completion response code
//   ID_VALUE                         : contents of the read-only ID register
// ---------------------------------------------------------------------------
package specConst;

  localparam int PROT_LEN   = 3;
  localparam int STROBE_LEN = 4;
  localparam int RESP_LEN   = 2;

  localparam logic [31:0] ID_VALUE = 32'hA5B0_0001;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic [RESP_LEN-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile_if: APB bus bundle between a requester and the register
// file.
//   requester drives : psel, penable, pwrite, paddr, pwdata, pstrb, pprot
//   completer drives : prdata, pready, pslverr
// Modports: master (requester side), slave (completer side).
// ---------------------------------------------------------------------------
interface apb_slave_regfile_if
  import specConst::*;
#(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
) ();

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDRWIDTH-1:0]  paddr;
  logic [DATAWIDTH-1:0]  pwdata;
  logic [STROBE_LEN-1:0] pstrb;
  logic [PROT_LEN-1:0]   pprot;
  logic [DATAWIDTH-1:0]  prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_regfile_reg_array.sv
// ---------------------------------------------------------------------------
// apb_reg_array: register storage with byte-strobe writes.
// Registers 0..NREGS-2 are writable; index NREGS-1 is the read-only ID.
// Ports:
//   clk, rst : clock, async active-low reset (clears writable registers)
//   we       : write enable for this cycle
//   widx     : register index to write
//   wdata    : write data
//   wstrb    : byte enables for the write
//   ridx     : register index to read
//   rdata    : combinational read data
// ---------------------------------------------------------------------------
module apb_reg_array
  import specConst::*;
#(
  parameter int NREGS     = 16,
  parameter int DATAWIDTH = 32,
  localparam int IDX_W    = $clog2(NREGS),
  localparam int NBYTES   = DATAWIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     widx,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [NBYTES-1:0]    wstrb,
  input  logic [IDX_W-1:0]     ridx,
  output logic [DATAWIDTH-1:0] rdata
);

  logic [DATAWIDTH-1:0] regs [NREGS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS - 1; r++) begin
        regs[r] <= '0;
      end
    end else if (we) begin
      for (int r = 0; r < NREGS - 1; r++) begin
        if (widx == IDX_W'(r)) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (wstrb[b]) begin
              regs[r][b*8 +: 8] <= wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // The ID slot has no storage, so it is the default of the read mux.
  always_comb begin
    rdata = DATAWIDTH'(ID_VALUE);
    for (int r = 0; r < NREGS - 1; r++) begin
      if (ridx == IDX_W'(r)) begin
        rdata = regs[r];
      end
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile: APB completer in front of a small register file.
// Setup phase fields are latched in IDLE; the transfer completes in ACCESS
// once the wait counter has run out. Errors: bad/unaligned address, write to
// the ID register, unprivileged write to register 0.
// Ports:
//   clk : clock, rising edge
//   rst : async active-low reset
//   bus : apb_slave_regfile_if.slave (APB request in, prdata/pready/pslverr out)
// Build option: APB_WAIT_STATES_EN -- when defined, WAIT_CYCLES wait states
// are inserted per transfer; otherwise every first access cycle completes.
// ---------------------------------------------------------------------------
module apb_slave_regfile
  import specConst::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int NREGS       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  apb_slave_regfile_if.slave bus
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [ADDRWIDTH-1:0] REG_SPAN = ADDRWIDTH'(NREGS * 4);

  state_t state, state_next;

  logic [ADDRWIDTH-1:0]  addr_q;
  logic                  write_q;
  logic [DATAWIDTH-1:0]  wdata_q;
  logic [STROBE_LEN-1:0] strb_q;
  logic [PROT_LEN-1:0]   prot_q;

  logic setup_hit;
  logic access_hit;
  logic wait_done;
  logic complete;
  logic err;
  logic reg_we;
  resp_t resp;

  logic [IDX_W-1:0]     idx;
  logic [DATAWIDTH-1:0] reg_rdata;

  logic unused_prot;
  assign unused_prot = ^prot_q[PROT_LEN-1:1];

  assign setup_hit  = (state == ST_IDLE) && bus.psel && !bus.penable;
  assign access_hit = (state == ST_ACCESS) && bus.psel && bus.penable;
  assign complete   = access_hit && wait_done;

`ifdef APB_WAIT_STATES_EN
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (setup_hit) begin
      cnt <= CNT_W'(WAIT_CYCLES);
    end else if (access_hit && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign wait_done = (cnt == '0);
`else
  assign wait_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else if (setup_hit) begin
      addr_q  <= bus.paddr;
      write_q <= bus.pwrite;
      wdata_q <= bus.pwdata;
      strb_q  <= bus.pstrb;
      prot_q  <= bus.pprot;
    end
  end

  assign idx = addr_q[2 +: IDX_W];

  // Error decode from the latched request only.
  always_comb begin
    err = 1'b0;
    if (addr_q >= REG_SPAN || addr_q[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (write_q && idx == IDX_W'(NREGS - 1)) begin
      err = 1'b1;
    end else if (write_q && idx == '0 && !prot_q[0]) begin
      err = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state. ACCESS with psel low is a requester abort.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (setup_hit) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!bus.psel || complete) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs. Everything is zero outside the completion cycle.
  always_comb begin
    resp        = RESP_OKAY;
    reg_we      = 1'b0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    if (complete) begin
      bus.pready = 1'b1;
      if (err) begin
        resp = RESP_SLVERR;
      end else if (write_q) begin
        reg_we = 1'b1;
      end else begin
        bus.prdata = reg_rdata;
      end
      bus.pslverr = (resp == RESP_SLVERR);
    end
  end

  apb_reg_array #(
    .NREGS     (NREGS),
    .DATAWIDTH (DATAWIDTH)
  ) u_reg_array (
    .clk   (clk),
    .rst   (rst),
    .we    (reg_we),
    .widx  (idx),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .ridx  (idx),
    .rdata (reg_rdata)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;
  import specConst::*;

  localparam int WAIT = 2;
`ifdef APB_WAIT_STATES_EN
  localparam int EXP_ACC = WAIT + 1;
`else
  localparam int EXP_ACC = 1;
`endif

  logic clk;
  logic rst;
  int checks;
  int failures;

  apb_slave_regfile_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus ();

  apb_slave_regfile #(
    .DATAWIDTH   (32),
    .ADDRWIDTH   (32),
    .NREGS       (16),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at a negedge with the bus idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rdata, output logic slverr, output int ncyc);
    bit done;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = data; bus.pstrb = strb; bus.pprot = prot;
    @(negedge clk);
    bus.penable = 1'b1;
    ncyc = 0; done = 0; rdata = '0; slverr = 1'b0;
    while (!done && ncyc < 16) begin
      ncyc++;
      #1;
      if (bus.pready === 1'b1) begin
        rdata = bus.prdata; slverr = bus.pslverr; done = 1;
      end
      @(negedge clk);
    end
    if (!done) check("timeout_pready", 32'(ncyc), 32'(EXP_ACC));
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          nc;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
    repeat (2) @(negedge clk);
    check("rst_pready", 32'(bus.pready), 32'd0);
    check("rst_pslverr", 32'(bus.pslverr), 32'd0);
    check("rst_prdata", bus.prdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    xfer(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, nc);
    check("wr8_latency", 32'(nc), 32'(EXP_ACC));
    check("wr8_slverr", 32'(er), 32'd0);
    check("wr8_prdata", rd, 32'd0);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rd8_data", rd, 32'hDEADBEEF);
    check("rd8_slverr", 32'(er), 32'd0);
    check("rd8_latency", 32'(nc), 32'(EXP_ACC));

    xfer(1'b1, 32'h8, 32'h11223344, 4'b0101, 3'b000, rd, er, nc);
    check("wr8_strb_slverr", 32'(er), 32'd0);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, 3'b000, rd, er, nc);
    check("rd8_strb_data", rd, 32'hDE22BE44);

    xfer(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 3'b000, rd, er, nc);
    check("wr8_nostrb_slverr", 32'(er), 32'd0);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rd8_nostrb_data", rd, 32'hDE22BE44);

    xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rd40_slverr", 32'(er), 32'd1);
    check("rd40_prdata", rd, 32'd0);
    xfer(1'b0, 32'h6, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rd6_slverr", 32'(er), 32'd1);
    check("rd6_prdata", rd, 32'd0);

    xfer(1'b1, 32'h0, 32'h1, 4'hF, 3'b000, rd, er, nc);
    check("wr0_unpriv_slverr", 32'(er), 32'd1);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rd0_after_unpriv", rd, 32'd0);
    xfer(1'b1, 32'h0, 32'h1, 4'hF, 3'b001, rd, er, nc);
    check("wr0_priv_slverr", 32'(er), 32'd0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rd0_after_priv", rd, 32'd1);

    xfer(1'b1, 32'h3C, 32'h12345678, 4'hF, 3'b001, rd, er, nc);
    check("wr3c_slverr", 32'(er), 32'd1);
    xfer(1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rd3c_id", rd, 32'hA5B0_0001);
    check("rd3c_slverr", 32'(er), 32'd0);

    // Requester abort in the first access cycle.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h4; bus.pwdata = 32'hCAFEF00D; bus.pstrb = 4'hF; bus.pprot = 3'b001;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b1;
    #1 check("abort_pready", 32'(bus.pready), 32'd0);
    @(negedge clk);
    bus.penable = 1'b0;
    #1 check("abort_pready_after", 32'(bus.pready), 32'd0);
    @(negedge clk);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("abort_reg1", rd, 32'd0);
    check("abort_idle_latency", 32'(nc), 32'(EXP_ACC));

    // penable without a setup phase is ignored in IDLE.
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
    bus.paddr = 32'h4; bus.pwdata = 32'h55AA55AA; bus.pstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1 check("nosetup_pready", 32'(bus.pready), 32'd0);
      @(negedge clk);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("nosetup_reg1", rd, 32'd0);

    // Back-to-back transfers: xfer returns and the next setup follows at once.
    xfer(1'b1, 32'hC, 32'hAAAA5555, 4'hF, 3'b000, rd, er, nc);
    xfer(1'b0, 32'hC, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("b2b_rdC", rd, 32'hAAAA5555);
    check("b2b_latency", 32'(nc), 32'(EXP_ACC));

    // Reset during the wait cycle of a write to reg1.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h4; bus.pwdata = 32'h12345678; bus.pstrb = 4'hF; bus.pprot = 3'b000;
    @(negedge clk);
    bus.penable = 1'b1;
    rst = 1'b0;
    #1 check("rstmid_pready", 32'(bus.pready), 32'd0);
    @(negedge clk);
    #1 check("rstmid_pready2", 32'(bus.pready), 32'd0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rstmid_reg1", rd, 32'd0);
    check("rstmid_idle_latency", 32'(nc), 32'(EXP_ACC));
    xfer(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rstmid_reg2_cleared", rd, 32'd0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, nc);
    check("rstmid_reg0_cleared", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
